// File: rtl/riscv_core_immpack.sv
// Immediate encoder: packs a 64-bit immediate into instr[31:7] for the
// selected format, flags immediates the format cannot represent, and
// delivers words through a two-stage valid/ready pipeline with counters.
module riscv_core_immpack #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_immpack_clk,
    input  logic             i_immpack_rst,
    input  logic             i_immpack_flush,
    input  logic             i_immpack_valid,
    output logic             o_immpack_ready,
    input  logic [63:0]      i_immpack_imm,
    input  logic [2:0]       i_immpack_immsrc,
    input  logic [24:0]      i_immpack_base,
    output logic             o_immpack_valid,
    input  logic             i_immpack_ready,
    output logic [24:0]      o_immpack_field,
    output logic             o_immpack_err,
    output logic [CNT_W-1:0] o_immpack_cnt,
    output logic [CNT_W-1:0] o_immpack_errcnt
);

    localparam int unsigned HOLD_W = 32;
    localparam int unsigned FLD_W  = 25;

    typedef enum logic [2:0] {
        SRC_I   = 3'b000,
        SRC_S   = 3'b001,
        SRC_B   = 3'b010,
        SRC_J   = 3'b011,
        SRC_U   = 3'b100,
        SRC_A   = 3'b101,
        SRC_CSR = 3'b110,
        SRC_ILL = 3'b111
    } immsrc_e;

    logic              s1_valid;
    logic [HOLD_W-1:0] s1_imm;
    immsrc_e           s1_src;
    logic [FLD_W-1:0]  s1_base;
    logic              s1_err;

    logic              adv1;
    logic              adv2;
    logic              in_err;
    logic [FLD_W-1:0]  pack_field;

    assign adv2 = !o_immpack_valid || i_immpack_ready;
    assign adv1 = !s1_valid || adv2;
    assign o_immpack_ready = adv1 && !i_immpack_flush && !i_immpack_rst;

    // Range/alignment check on the incoming immediate
    always_comb begin
        in_err = 1'b1;
        case (immsrc_e'(i_immpack_immsrc))
            SRC_I, SRC_S: in_err = !(&i_immpack_imm[63:11] || ~|i_immpack_imm[63:11]);
            SRC_B:   in_err = !((&i_immpack_imm[63:12] || ~|i_immpack_imm[63:12]) && !i_immpack_imm[0]);
            SRC_J:   in_err = !((&i_immpack_imm[63:20] || ~|i_immpack_imm[63:20]) && !i_immpack_imm[0]);
            SRC_U:   in_err = !((&i_immpack_imm[63:31] || ~|i_immpack_imm[63:31]) && ~|i_immpack_imm[11:0]);
            SRC_A:   in_err = |i_immpack_imm;
            SRC_CSR: in_err = |i_immpack_imm[63:5];
            default: in_err = 1'b1;
        endcase
    end

    // Scatter the stage-1 immediate into the instruction field; errors keep base
    always_comb begin
        pack_field = s1_base;
        if (!s1_err) begin
            case (s1_src)
                SRC_I: pack_field[24:13] = s1_imm[11:0];
                SRC_S: begin
                    pack_field[24:18] = s1_imm[11:5];
                    pack_field[4:0]   = s1_imm[4:0];
                end
                SRC_B: begin
                    pack_field[24]    = s1_imm[12];
                    pack_field[23:18] = s1_imm[10:5];
                    pack_field[4:1]   = s1_imm[4:1];
                    pack_field[0]     = s1_imm[11];
                end
                SRC_J: begin
                    pack_field[24]    = s1_imm[20];
                    pack_field[23:14] = s1_imm[10:1];
                    pack_field[13]    = s1_imm[11];
                    pack_field[12:5]  = s1_imm[19:12];
                end
                SRC_U:   pack_field[24:5] = s1_imm[31:12];
                SRC_CSR: pack_field[12:8] = s1_imm[4:0];
                default: pack_field = s1_base;
            endcase
        end
    end

    // Stage 1: capture the accepted word and its legality
    always_ff @(posedge i_immpack_clk or posedge i_immpack_rst) begin
        if (i_immpack_rst) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_src   <= SRC_I;
            s1_base  <= '0;
            s1_err   <= 1'b0;
        end else if (i_immpack_flush) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= i_immpack_valid;
            if (i_immpack_valid) begin
                s1_imm  <= i_immpack_imm[HOLD_W-1:0];
                s1_src  <= immsrc_e'(i_immpack_immsrc);
                s1_base <= i_immpack_base;
                s1_err  <= in_err;
            end
        end
    end

    // Stage 2: registered output word, held while downstream stalls
    always_ff @(posedge i_immpack_clk or posedge i_immpack_rst) begin
        if (i_immpack_rst) begin
            o_immpack_valid <= 1'b0;
            o_immpack_field <= '0;
            o_immpack_err   <= 1'b0;
        end else if (i_immpack_flush) begin
            o_immpack_valid <= 1'b0;
        end else if (adv2) begin
            o_immpack_valid <= s1_valid;
            if (s1_valid) begin
                o_immpack_field <= pack_field;
                o_immpack_err   <= s1_err;
            end
        end
    end

    // Delivered-word counter (wraps) and error counter (saturates)
    always_ff @(posedge i_immpack_clk or posedge i_immpack_rst) begin
        if (i_immpack_rst) begin
            o_immpack_cnt    <= '0;
            o_immpack_errcnt <= '0;
        end else if (o_immpack_valid && i_immpack_ready) begin
            o_immpack_cnt <= o_immpack_cnt + CNT_W'(1);
            if (o_immpack_err && (o_immpack_errcnt != {CNT_W{1'b1}})) begin
                o_immpack_errcnt <= o_immpack_errcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_immpack.sv
// Directed and randomized checks for the immediate encoder pipeline,
// with an independent immediate-extender model for round-trip checks.
module tb_riscv_core_immpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_imm = '0;
    logic [2:0]  in_src = '0;
    logic [24:0] in_base = '0;
    logic        out_ready = 1'b0;
    logic        rdy, rdy4, ov, ov4, er, er4;
    logic [24:0] fld, fld4;
    logic [15:0] cnt, errcnt;
    logic [3:0]  cnt4, errcnt4;

    int total = 0;
    int bad = 0;
    int n_sent = 0;
    int n_err = 0;
    bit rnd_bp = 1'b0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  src;
        logic [24:0] base;
        logic [24:0] field;
        logic        use_field;
        logic        err;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    riscv_core_immpack #(.CNT_W(16)) dut (
        .i_immpack_clk(clk), .i_immpack_rst(rst), .i_immpack_flush(flush),
        .i_immpack_valid(in_valid), .o_immpack_ready(rdy), .i_immpack_imm(in_imm),
        .i_immpack_immsrc(in_src), .i_immpack_base(in_base), .o_immpack_valid(ov),
        .i_immpack_ready(out_ready), .o_immpack_field(fld), .o_immpack_err(er),
        .o_immpack_cnt(cnt), .o_immpack_errcnt(errcnt)
    );

    riscv_core_immpack #(.CNT_W(4)) dut4 (
        .i_immpack_clk(clk), .i_immpack_rst(rst), .i_immpack_flush(flush),
        .i_immpack_valid(in_valid), .o_immpack_ready(rdy4), .i_immpack_imm(in_imm),
        .i_immpack_immsrc(in_src), .i_immpack_base(in_base), .o_immpack_valid(ov4),
        .i_immpack_ready(out_ready), .o_immpack_field(fld4), .o_immpack_err(er4),
        .o_immpack_cnt(cnt4), .o_immpack_errcnt(errcnt4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference immediate extender: field (instr[31:7]) back to a 64-bit value
    function automatic logic [63:0] extend(input logic [24:0] f, input logic [2:0] src);
        case (src)
            3'd0:    return {{52{f[24]}}, f[24:13]};
            3'd1:    return {{52{f[24]}}, f[24:18], f[4:0]};
            3'd2:    return {{51{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
            3'd3:    return {{43{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
            3'd4:    return {{32{f[24]}}, f[24:5], 12'h000};
            3'd6:    return {59'd0, f[12:8]};
            default: return 64'd0;
        endcase
    endfunction

    // Field bits that carry immediate data in each format
    function automatic logic [24:0] imask(input logic [2:0] src);
        case (src)
            3'd0:       return 25'h1FFE000;
            3'd1, 3'd2: return 25'h1FC001F;
            3'd3, 3'd4: return 25'h1FFFFE0;
            3'd6:       return 25'h0001F00;
            default:    return 25'h0000000;
        endcase
    endfunction

    // Random immediate, in range for the format or deliberately out of range
    function automatic logic [63:0] gen(input logic [2:0] src, input bit oor);
        logic [63:0] r;
        logic [63:0] v;
        int unsigned p;
        r = {$urandom, $urandom};
        case (src)
            3'd0, 3'd1: begin
                v = {{52{r[11]}}, r[11:0]};
                if (oor) begin p = $urandom_range(63, 11); v[p] = ~v[p]; end
            end
            3'd2: begin
                v = {{51{r[12]}}, r[12:1], 1'b0};
                if (oor) begin
                    if (r[40]) v[0] = 1'b1;
                    else begin p = $urandom_range(63, 12); v[p] = ~v[p]; end
                end
            end
            3'd3: begin
                v = {{43{r[20]}}, r[20:1], 1'b0};
                if (oor) begin
                    if (r[40]) v[0] = 1'b1;
                    else begin p = $urandom_range(63, 20); v[p] = ~v[p]; end
                end
            end
            3'd4: begin
                v = {{32{r[31]}}, r[31:12], 12'h000};
                if (oor) begin
                    if (r[40]) begin p = $urandom_range(11, 0); v[p] = 1'b1; end
                    else begin p = $urandom_range(63, 31); v[p] = ~v[p]; end
                end
            end
            3'd5: v = oor ? (r | 64'h1) : 64'h0;
            3'd6: begin
                v = {59'd0, r[4:0]};
                if (oor) begin p = $urandom_range(63, 5); v[p] = 1'b1; end
            end
            default: v = r;
        endcase
        return v;
    endfunction

    // Scoreboard: every delivered word is checked against the expected queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_word", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("err", 64'(er), 64'(e.err));
                chk("err4", 64'(er4), 64'(e.err));
                chk("field4_base", 64'(fld4 & ~imask(e.src)), 64'(e.base & ~imask(e.src)));
                if (e.use_field) chk("field", 64'(fld), 64'(e.field));
                else if (e.err) chk("field_is_base", 64'(fld), 64'(e.base));
                else begin
                    chk("roundtrip", extend(fld, e.src), e.imm);
                    chk("base_kept", 64'(fld & ~imask(e.src)), 64'(e.base & ~imask(e.src)));
                end
            end
        end
    end

    // Random downstream backpressure during the random phase
    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 out_ready = ($urandom_range(3, 0) != 0);
        end
    end

    task automatic send(input logic [63:0] imm, input logic [2:0] src, input logic [24:0] base,
                        input logic [24:0] ef, input logic uf, input logic ee);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_imm = imm;
        in_src = src;
        in_base = base;
        while (!ok && n < 60) begin
            @(negedge clk);
            ok = rdy;
            @(posedge clk);
            n++;
        end
        if (ok) begin
            q.push_back('{imm, src, base, ef, uf, ee});
            n_sent++;
            if (ee) n_err++;
        end else begin
            chk("send_timeout", 64'd0, 64'd1);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ready_in_reset", 64'(rdy), 64'd0);
        chk("ready4_in_reset", 64'(rdy4), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        n_sent = 0;
        n_err = 0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_valid", 64'(ov), 64'd0);
        chk("rst_field", 64'(fld), 64'd0);
        chk("rst_err", 64'(er), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_errcnt", 64'(errcnt), 64'd0);
        chk("rst_ready", 64'(rdy), 64'd1);
        @(posedge clk);
        #1;

        // Latency: o_valid appears in the second cycle after the accept cycle
        out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 25'h0, 25'h1FFE000, 1'b1, 1'b0);
        @(negedge clk);
        chk("lat_cycle1", 64'(ov), 64'd0);
        @(negedge clk);
        chk("lat_cycle2", 64'(ov), 64'd1);
        drain();

        // Directed format vectors
        send(64'h800, 3'd2, 25'h0, 25'h0000001, 1'b1, 1'b0);
        send(64'h801, 3'd2, 25'h00ABCDE, 25'h00ABCDE, 1'b1, 1'b1);
        drain();
        chk("errcnt_b801", 64'(errcnt), 64'd1);
        send(64'h1000, 3'd2, 25'h1234567, 25'h1234567, 1'b1, 1'b1);
        send(64'h1234_5000, 3'd4, 25'h0, 25'h02468A0, 1'b1, 1'b0);
        send(64'h1234_5001, 3'd4, 25'h0000F0F, 25'h0000F0F, 1'b1, 1'b1);
        send(64'h1F, 3'd6, 25'h1555555, 25'h1555F55, 1'b1, 1'b0);
        send(64'h0, 3'd7, 25'h0000001, 25'h0000001, 1'b1, 1'b1);
        drain();
        chk("cnt_directed", 64'(cnt), 64'd8);
        chk("errcnt_directed", 64'(errcnt), 64'd4);

        // Backpressure: third word waits at the input until downstream opens
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                send(64'h001, 3'd0, 25'h0, 25'h0002000, 1'b1, 1'b0);
                send(64'h002, 3'd0, 25'h0, 25'h0004000, 1'b1, 1'b0);
                send(64'h003, 3'd0, 25'h0, 25'h0006000, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_ready_low", 64'(rdy), 64'd0);
                chk("bp_out_held", 64'(ov), 64'd1);
                chk("bp_field_held", 64'(fld), 64'h0002000);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_no_gap", 64'(ov), 64'd1);
                end
            end
        join
        drain();
        chk("bp_cnt", 64'(cnt), 64'd3);

        // Flush with two words in flight and a simultaneous input
        do_reset();
        out_ready = 1'b0;
        send(64'h010, 3'd0, 25'h0, 25'h0020000, 1'b1, 1'b0);
        send(64'h020, 3'd0, 25'h0, 25'h0040000, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_imm = 64'h030;
        in_src = 3'd0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(rdy), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_valid", 64'(ov), 64'd0);
        chk("flush_cnt", 64'(cnt), 64'd0);
        @(negedge clk);
        chk("flush_not_accepted", 64'(ov), 64'd0);
        @(posedge clk);
        #1;

        // Flush while the output word is handed off: that handshake counts
        send(64'h040, 3'd0, 25'h0, 25'h0080000, 1'b1, 1'b0);
        send(64'h050, 3'd0, 25'h0, 25'h00A0000, 1'b1, 1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_hs_valid", 64'(ov), 64'd0);
        chk("flush_hs_cnt", 64'(cnt), 64'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        do_reset();
        out_ready = 1'b1;
        send(64'h801, 3'd2, 25'h1ABCDEF, 25'h1ABCDEF, 1'b1, 1'b1);
        drain();
        chk("pre_rst_errcnt", 64'(errcnt), 64'd1);
        out_ready = 1'b0;
        send(64'h060, 3'd0, 25'h0, 25'h00C0000, 1'b1, 1'b0);
        send(64'h070, 3'd0, 25'h0, 25'h00E0000, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ov), 64'd0);
        chk("arst_field", 64'(fld), 64'd0);
        chk("arst_err", 64'(er), 64'd0);
        chk("arst_cnt", 64'(cnt), 64'd0);
        chk("arst_errcnt", 64'(errcnt), 64'd0);
        chk("arst_ready", 64'(rdy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_no_partial", 64'(ov), 64'd0);
        end
        @(posedge clk);
        #1;

        // Random round-trip through the extender model, with out-of-range words
        do_reset();
        rnd_bp = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 150; k++) begin
                bit oor;
                logic [63:0] v;
                oor = (k % 4 == 3);
                v = gen(3'(s), oor);
                send(v, 3'(s), 25'($urandom), 25'h0, 1'b0, oor || (s == 7));
            end
        end
        @(posedge clk);
        rnd_bp = 1'b0;
        #2;
        drain();
        chk("rnd_cnt", 64'(cnt), 64'(n_sent));
        chk("rnd_errcnt", 64'(errcnt), 64'(n_err));
        chk("rnd_cnt4_wrap", 64'(cnt4), 64'(n_sent % 16));
        chk("rnd_errcnt4_sat", 64'(errcnt4), 64'((n_err >= 15) ? 15 : n_err));
        chk("rnd_idle", 64'(ov4), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
